noc_output_allocator: RTL and testbench



---
 rtl/noc_pkg.sv | 14 +
 rtl/noc_rr_arbiter.sv | 32 +++
 rtl/noc_output_allocator.sv | 115 +++++++++++
 tb/tb_noc_output_allocator.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router types: allocator state encoding and the round-robin pointer wrap helper.
package noc_pkg;

   typedef enum logic {
      ALLOC_IDLE   = 1'b0,
      ALLOC_LOCKED = 1'b1
   } alloc_state_t;

   // Explicit wrap so non-power-of-two port counts never leave the valid index range.
   function automatic int rr_next(input int ptr, input int n);
      return (ptr + 1 >= n) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/noc_rr_arbiter.sv
// Combinational rotate-priority arbiter: the first requester at or after ptr wins, wrapping at N-1.
module noc_rr_arbiter #(
   parameter int N     = 5,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             any
);

   always_comb begin
      int idx;
      // NOTE: combinational blocks use blocking assignments, and every output gets a default
      // first so no path through the loop can leave a latch behind.
      gnt     = '0;
      gnt_idx = '0;
      any     = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         if (!any && req[idx]) begin
            any      = 1'b1;
            gnt[idx] = 1'b1;
            gnt_idx  = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/noc_output_allocator.sv
// Per-output wormhole switch allocator: round-robin head arbitration, packet lock, downstream credits.
module noc_output_allocator
   import noc_pkg::*;
#(
   parameter int NUM_INPUTS        = 5,
   parameter int FLIT_BUFFER_DEPTH = 4,
   parameter int IDX_W             = $clog2(NUM_INPUTS),
   parameter int CNT_W             = $clog2(FLIT_BUFFER_DEPTH + 1)
) (
   input  logic                  clk_noc,
   input  logic                  rst_n,
   input  logic [NUM_INPUTS-1:0] req,
   input  logic [NUM_INPUTS-1:0] is_tail,
   input  logic [NUM_INPUTS-1:0] turn_mask,
   input  logic                  credit_in,
   output logic [NUM_INPUTS-1:0] grant,
   output logic                  send_out,
   output logic [IDX_W-1:0]      owner_idx,
   output logic                  locked,
   output logic [CNT_W-1:0]      credit_count,
   output logic                  credit_overflow
);

   localparam logic [CNT_W-1:0] CREDIT_MAX = CNT_W'(FLIT_BUFFER_DEPTH);

   alloc_state_t     state_q;
   logic [IDX_W-1:0] owner_q;
   logic [IDX_W-1:0] rr_ptr;
   logic [CNT_W-1:0] credit_q;
   logic             overflow_q;

   logic                  credit_ok;
   logic [NUM_INPUTS-1:0] arb_gnt;
   logic [IDX_W-1:0]      arb_idx;
   logic                  arb_any;
   logic [NUM_INPUTS-1:0] grant_c;
   logic [IDX_W-1:0]      owner_c;

   assign credit_ok = (credit_q != '0);

   // Turn restrictions only apply to packet heads, so the mask feeds the arbiter and nothing else.
   noc_rr_arbiter #(
      .N     (NUM_INPUTS),
      .IDX_W (IDX_W)
   ) u_arb (
      .req     (req & ~turn_mask),
      .ptr     (rr_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .any     (arb_any)
   );

   always_comb begin
      grant_c = '0;
      owner_c = '0;
      if (state_q == ALLOC_IDLE) begin
         owner_c = arb_idx;
         if (credit_ok && arb_any) grant_c = arb_gnt;
      end else begin
         owner_c = owner_q;
         if (req[owner_q] && credit_ok) grant_c[owner_q] = 1'b1;
      end
   end

   // Grant paths are combinational from req, so they are forced quiet while reset is held.
   assign grant           = rst_n ? grant_c : '0;
   assign owner_idx       = rst_n ? owner_c : '0;
   assign send_out        = |grant;
   assign locked          = (state_q == ALLOC_LOCKED);
   assign credit_count    = credit_q;
   assign credit_overflow = overflow_q;

   always_ff @(posedge clk_noc or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ALLOC_IDLE;
         owner_q    <= '0;
         rr_ptr     <= '0;
         credit_q   <= CREDIT_MAX;
         overflow_q <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every register samples
         // the pre-edge values regardless of statement order.
         case (state_q)
            ALLOC_IDLE: begin
               if (send_out) begin
                  if (is_tail[arb_idx]) begin
                     rr_ptr <= IDX_W'(rr_next(int'(arb_idx), NUM_INPUTS));
                  end else begin
                     state_q <= ALLOC_LOCKED;
                     owner_q <= arb_idx;
                  end
               end
            end
            ALLOC_LOCKED: begin
               if (send_out && is_tail[owner_q]) begin
                  state_q <= ALLOC_IDLE;
                  rr_ptr  <= IDX_W'(rr_next(int'(owner_q), NUM_INPUTS));
               end
            end
            default: state_q <= ALLOC_IDLE;
         endcase

         // A grant needs a nonzero count, so the decrement can never wrap below zero.
         case ({send_out, credit_in})
            2'b10: credit_q <= credit_q - CNT_W'(1);
            2'b01: begin
               if (credit_q == CREDIT_MAX) overflow_q <= 1'b1;
               else                        credit_q   <= credit_q + CNT_W'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_noc_output_allocator.sv
// Vector-table bench for noc_output_allocator with a queue of expected per-cycle outputs.
module tb_noc_output_allocator;

   localparam int N = 5;

   typedef struct packed {
      logic [N-1:0] req;
      logic [N-1:0] tail;
      logic [N-1:0] mask;
      logic         cin;
      logic [N-1:0] grant;
      logic [2:0]   owner;
      logic         locked;
      logic [2:0]   count;
      logic         ovf;
   } vec_t;

   logic         clk_noc = 1'b0;
   logic         rst_n;
   logic [N-1:0] req, is_tail, turn_mask;
   logic         credit_in;
   logic [N-1:0] grant;
   logic         send_out;
   logic [2:0]   owner_idx;
   logic         locked;
   logic [2:0]   credit_count;
   logic         credit_overflow;

   int   n_vec = 0;
   int   n_err = 0;
   vec_t vecs[$];
   vec_t exp_q[$];

   always #5 clk_noc = ~clk_noc;

   noc_output_allocator dut (
      .clk_noc         (clk_noc),
      .rst_n           (rst_n),
      .req             (req),
      .is_tail         (is_tail),
      .turn_mask       (turn_mask),
      .credit_in       (credit_in),
      .grant           (grant),
      .send_out        (send_out),
      .owner_idx       (owner_idx),
      .locked          (locked),
      .credit_count    (credit_count),
      .credit_overflow (credit_overflow)
   );

   function automatic vec_t mk(input logic [N-1:0] r, input logic [N-1:0] t, input logic [N-1:0] m,
                               input logic c, input logic [N-1:0] g, input int o, input logic l,
                               input int cnt, input logic ov);
      vec_t v;
      v.req = r; v.tail = t; v.mask = m; v.cin = c; v.grant = g;
      v.owner = 3'(o); v.locked = l; v.count = 3'(cnt); v.ovf = ov;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive at the falling edge, queue the expectation, then compare mid-cycle before the rising edge.
   task automatic run_vec(input int id, input vec_t v);
      vec_t e;
      @(negedge clk_noc);
      req = v.req; is_tail = v.tail; turn_mask = v.mask; credit_in = v.cin;
      exp_q.push_back(v);
      #2;
      e = exp_q.pop_front();
      check($sformatf("v%0d grant", id),  32'(grant),           32'(e.grant));
      check($sformatf("v%0d send", id),   32'(send_out),        32'(|e.grant));
      check($sformatf("v%0d locked", id), 32'(locked),          32'(e.locked));
      check($sformatf("v%0d count", id),  32'(credit_count),    32'(e.count));
      check($sformatf("v%0d ovf", id),    32'(credit_overflow), 32'(e.ovf));
      if (e.grant != '0 || e.locked)
         check($sformatf("v%0d owner", id), 32'(owner_idx), 32'(e.owner));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " grant"},  32'(grant),           32'(0));
      check({tag, " send"},   32'(send_out),        32'(0));
      check({tag, " locked"}, 32'(locked),          32'(0));
      check({tag, " owner"},  32'(owner_idx),       32'(0));
      check({tag, " count"},  32'(credit_count),    32'(4));
      check({tag, " ovf"},    32'(credit_overflow), 32'(0));
   endtask

   initial begin
      // Two single-flit heads on consecutive cycles, then refill.
      vecs.push_back(mk(5'b00110, 5'b11111, 5'b0, 1'b0, 5'b00010, 1, 1'b0, 4, 1'b0));
      vecs.push_back(mk(5'b00110, 5'b11111, 5'b0, 1'b0, 5'b00100, 2, 1'b0, 3, 1'b0));
      vecs.push_back(mk(5'b00000, 5'b00000, 5'b0, 1'b1, 5'b00000, 0, 1'b0, 2, 1'b0));
      vecs.push_back(mk(5'b00000, 5'b00000, 5'b0, 1'b1, 5'b00000, 0, 1'b0, 3, 1'b0));
      // Three-flit packet on input 3 with input 0 waiting; input 0 then wraps the pointer to 1.
      vecs.push_back(mk(5'b01001, 5'b00001, 5'b0, 1'b0, 5'b01000, 3, 1'b0, 4, 1'b0));
      vecs.push_back(mk(5'b01001, 5'b00001, 5'b0, 1'b0, 5'b01000, 3, 1'b1, 3, 1'b0));
      vecs.push_back(mk(5'b01001, 5'b01001, 5'b0, 1'b0, 5'b01000, 3, 1'b1, 2, 1'b0));
      vecs.push_back(mk(5'b00001, 5'b00001, 5'b0, 1'b0, 5'b00001, 0, 1'b0, 1, 1'b0));
      vecs.push_back(mk(5'b00011, 5'b11111, 5'b0, 1'b1, 5'b00000, 0, 1'b0, 0, 1'b0));
      vecs.push_back(mk(5'b00011, 5'b11111, 5'b0, 1'b0, 5'b00010, 1, 1'b0, 1, 1'b0));
      for (int c = 0; c < 4; c++)
         vecs.push_back(mk(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, 0, 1'b0, c, 1'b0));
      // Credits run dry mid-packet on input 2; one credit releases exactly one flit.
      vecs.push_back(mk(5'b00100, 5'b0, 5'b0, 1'b0, 5'b00100, 2, 1'b0, 4, 1'b0));
      for (int c = 3; c >= 1; c--)
         vecs.push_back(mk(5'b00100, 5'b0, 5'b0, 1'b0, 5'b00100, 2, 1'b1, c, 1'b0));
      vecs.push_back(mk(5'b00100, 5'b0, 5'b0, 1'b0, 5'b00000, 2, 1'b1, 0, 1'b0));
      vecs.push_back(mk(5'b00100, 5'b0, 5'b0, 1'b1, 5'b00000, 2, 1'b1, 0, 1'b0));
      vecs.push_back(mk(5'b00100, 5'b0, 5'b0, 1'b0, 5'b00100, 2, 1'b1, 1, 1'b0));
      vecs.push_back(mk(5'b00100, 5'b0, 5'b0, 1'b0, 5'b00000, 2, 1'b1, 0, 1'b0));
      // Send plus credit at count 2 holds the count; tail then releases the lock.
      vecs.push_back(mk(5'b00000, 5'b0, 5'b0, 1'b1, 5'b00000, 2, 1'b1, 0, 1'b0));
      vecs.push_back(mk(5'b00000, 5'b0, 5'b0, 1'b1, 5'b00000, 2, 1'b1, 1, 1'b0));
      vecs.push_back(mk(5'b00100, 5'b0, 5'b0, 1'b1, 5'b00100, 2, 1'b1, 2, 1'b0));
      vecs.push_back(mk(5'b00100, 5'b00100, 5'b0, 1'b0, 5'b00100, 2, 1'b1, 2, 1'b0));
      // Refill to full, then one extra credit saturates and sets the sticky overflow.
      for (int c = 1; c <= 3; c++)
         vecs.push_back(mk(5'b0, 5'b0, 5'b0, 1'b1, 5'b0, 0, 1'b0, c, 1'b0));
      vecs.push_back(mk(5'b00000, 5'b0, 5'b0, 1'b1, 5'b0, 0, 1'b0, 4, 1'b0));
      vecs.push_back(mk(5'b00000, 5'b0, 5'b0, 1'b0, 5'b0, 0, 1'b0, 4, 1'b1));
      vecs.push_back(mk(5'b00001, 5'b11111, 5'b0, 1'b0, 5'b00001, 0, 1'b0, 4, 1'b1));
      vecs.push_back(mk(5'b00000, 5'b0, 5'b0, 1'b1, 5'b0, 0, 1'b0, 3, 1'b1));
      // Turn mask blocks a head, but not a packet already holding the output.
      vecs.push_back(mk(5'b00010, 5'b11111, 5'b00010, 1'b0, 5'b00000, 0, 1'b0, 4, 1'b1));
      vecs.push_back(mk(5'b00010, 5'b00000, 5'b00000, 1'b0, 5'b00010, 1, 1'b0, 4, 1'b1));
      vecs.push_back(mk(5'b00010, 5'b00000, 5'b00010, 1'b0, 5'b00010, 1, 1'b1, 3, 1'b1));
      vecs.push_back(mk(5'b00010, 5'b00010, 5'b00010, 1'b0, 5'b00010, 1, 1'b1, 2, 1'b1));
      vecs.push_back(mk(5'b00010, 5'b00000, 5'b00010, 1'b0, 5'b00000, 0, 1'b0, 1, 1'b1));
      // Head of a packet on input 3 that reset will interrupt.
      vecs.push_back(mk(5'b01000, 5'b00000, 5'b00000, 1'b0, 5'b01000, 3, 1'b0, 1, 1'b1));

      rst_n = 1'b0; req = '0; is_tail = '0; turn_mask = '0; credit_in = 1'b0;
      repeat (2) @(negedge clk_noc);
      #2 check_reset_outputs("reset");
      @(negedge clk_noc);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

      // Mid-packet async reset with the owner still requesting.
      @(negedge clk_noc);
      req = 5'b01000; is_tail = '0; turn_mask = '0; credit_in = 1'b1;
      #2;
      check("pre_rst locked", 32'(locked),       32'(1));
      check("pre_rst grant",  32'(grant),        32'(0));
      check("pre_rst owner",  32'(owner_idx),    32'(3));
      check("pre_rst count",  32'(credit_count), 32'(0));
      #1 rst_n = 1'b0;
      #1 check_reset_outputs("async_rst");
      @(negedge clk_noc);
      credit_in = 1'b0;
      #2 check_reset_outputs("held_rst");
      req = '0;
      @(negedge clk_noc);
      rst_n = 1'b1;
      run_vec(100, mk(5'b00011, 5'b11111, 5'b0, 1'b0, 5'b00001, 0, 1'b0, 4, 1'b0));

      check("scoreboard drained", 32'(exp_q.size()), 32'(0));
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
